// File: rtl/mole_anim_scheduler.sv
// mole_anim_scheduler
//   Runs one rise/hold/fall animation per hole. All holes step on a shared
//   frame tick, but each hole starts and stops on its own, so they move out
//   of phase with each other and can react to hits.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         1 = frame tick counter runs, 0 = frames frozen
//   map        per hole, level: game logic wants the mole up
//   hit        per hole, one-cycle pulse: player whacked that hole
//   frames     packed frame indices, hole i at [i*FRAME_W +: FRAME_W]
//   visible    per hole, registered (frame != 0)
//   hit_ack    per hole, one-cycle pulse: the hit was taken
//   retracted  per hole, one-cycle pulse: the hole fell back to frame 0
module mole_anim_scheduler #(
  parameter int N_HOLES   = 9,
  parameter int TICK_DIV  = 3125000,
  parameter int MAX_FRAME = 16,
  parameter int FRAME_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [N_HOLES-1:0]           map,
  input  logic [N_HOLES-1:0]           hit,
  output logic [N_HOLES*FRAME_W-1:0]   frames,
  output logic [N_HOLES-1:0]           visible,
  output logic [N_HOLES-1:0]           hit_ack,
  output logic [N_HOLES-1:0]           retracted
);

  localparam int                 CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(MAX_FRAME);
  localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

  typedef enum logic [1:0] {IDLE, RISE, HOLD, FALL} hole_state_t;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = en && (tick_cnt == TICK_LAST);

  // Shared frame divider. It only advances while enabled, so pausing keeps
  // the phase of the next tick exactly where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (en) begin
      if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + CNT_ONE;
    end
  end

  for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
    hole_state_t      state, state_next;
    logic [FRAME_W-1:0] frame, frame_next;
    logic             lock, lock_next;
    logic             ack_next, retract_next;
    logic             visible_r, ack_r, retract_r;

    // Next state for one hole. The frame step is decided by the state at the
    // start of the cycle. An accepted hit sets lock even when map drops in the
    // same cycle. This way the whacked mole stays down until map is dropped
    // and raised again.
    always_comb begin
      state_next   = state;
      frame_next   = frame;
      lock_next    = lock;
      ack_next     = 1'b0;
      retract_next = 1'b0;
      if (!map[i]) lock_next = 1'b0;
      case (state)
        IDLE: begin
          if (map[i] && !lock) state_next = RISE;
        end
        RISE: begin
          if (tick && (frame < FRAME_MAX)) frame_next = frame + FRAME_ONE;
          if (hit[i]) begin
            state_next = FALL;
            lock_next  = 1'b1;
            ack_next   = 1'b1;
          end else if (!map[i]) begin
            state_next = FALL;
          end else if (frame_next == FRAME_MAX) begin
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (hit[i]) begin
            state_next = FALL;
            lock_next  = 1'b1;
            ack_next   = 1'b1;
          end else if (!map[i]) begin
            state_next = FALL;
          end
        end
        FALL: begin
          if (tick && (frame != '0)) frame_next = frame - FRAME_ONE;
          // A fall that never left frame 0 drops straight back to IDLE.
          // There is nothing on screen, so no retracted pulse is sent.
          if (frame_next == '0) begin
            state_next   = IDLE;
            retract_next = (frame != '0);
          end else if (map[i] && !lock) begin
            state_next = RISE;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Per-hole registers. visible and retracted are taken from the next
    // frame, so they line up with the frame index they describe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        frame     <= '0;
        lock      <= 1'b0;
        visible_r <= 1'b0;
        ack_r     <= 1'b0;
        retract_r <= 1'b0;
      end else begin
        state     <= state_next;
        frame     <= frame_next;
        lock      <= lock_next;
        visible_r <= (frame_next != '0);
        ack_r     <= ack_next;
        retract_r <= retract_next;
      end
    end

    assign frames[i*FRAME_W +: FRAME_W] = frame;
    assign visible[i]   = visible_r;
    assign hit_ack[i]   = ack_r;
    assign retracted[i] = retract_r;
  end

endmodule

// File: tb/tb_mole_anim_scheduler.sv
// Directed bench for mole_anim_scheduler with TICK_DIV=4 and MAX_FRAME=16.
// After each reset release the cycles are counted from 1. With en held high,
// frame steps land on cycles 4, 8, 12, ...
module tb_mole_anim_scheduler;
  localparam int NH = 9;
  localparam int FW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NH-1:0]     map;
  logic [NH-1:0]     hit;
  logic [NH*FW-1:0]  frames;
  logic [NH-1:0]     visible;
  logic [NH-1:0]     hit_ack;
  logic [NH-1:0]     retracted;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mole_anim_scheduler #(
    .N_HOLES(NH), .TICK_DIV(4), .MAX_FRAME(16), .FRAME_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .map(map), .hit(hit),
    .frames(frames), .visible(visible), .hit_ack(hit_ack), .retracted(retracted)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] fr(input int h);
    return frames[h*FW +: FW];
  endfunction

  // Advance to a given cycle number after reset release, sampling 1ns after each edge.
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic apply_reset;
    rst = 1'b1; en = 1'b1; map = '0; hit = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; map = '0; hit = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (frames !== '0)    begin errors++; $display("[TB] FAIL reset_frames got=%h exp=0", frames); end
    checks++; if (visible !== '0)   begin errors++; $display("[TB] FAIL reset_visible got=%b exp=0", visible); end
    checks++; if (hit_ack !== '0)   begin errors++; $display("[TB] FAIL reset_hit_ack got=%b exp=0", hit_ack); end
    checks++; if (retracted !== '0) begin errors++; $display("[TB] FAIL reset_retracted got=%b exp=0", retracted); end
  endtask

  task automatic test_rise_hold_fall;
    int ret_cnt, ret_cyc;
    apply_reset();
    map[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      go_to(4*k - 1);
      checks++; if (fr(0) !== FW'(k-1)) begin errors++; $display("[TB] FAIL rise_pre cyc=%0d got=%0d exp=%0d", cyc, fr(0), k-1); end
      go_to(4*k);
      checks++; if (fr(0) !== FW'(k)) begin errors++; $display("[TB] FAIL rise_step cyc=%0d got=%0d exp=%0d", cyc, fr(0), k); end
    end
    checks++; if (visible[0] !== 1'b1) begin errors++; $display("[TB] FAIL rise_visible got=%b exp=1", visible[0]); end
    go_to(72);
    checks++; if (fr(0) !== 5'd16) begin errors++; $display("[TB] FAIL hold_frame got=%0d exp=16", fr(0)); end
    map[0] = 1'b0;
    ret_cnt = 0; ret_cyc = -1;
    for (int c = 73; c <= 140; c++) begin
      go_to(c);
      if (retracted[0]) begin ret_cnt++; ret_cyc = c; end
      if (((c - 72) % 4 == 0) && (c <= 136)) begin
        checks++;
        if (fr(0) !== FW'(16 - (c - 72)/4)) begin errors++; $display("[TB] FAIL fall_step cyc=%0d got=%0d exp=%0d", c, fr(0), 16 - (c-72)/4); end
      end
    end
    checks++; if (ret_cnt != 1)   begin errors++; $display("[TB] FAIL retract_count got=%0d exp=1", ret_cnt); end
    checks++; if (ret_cyc != 136) begin errors++; $display("[TB] FAIL retract_cycle got=%0d exp=136", ret_cyc); end
    checks++; if (visible[0] !== 1'b0) begin errors++; $display("[TB] FAIL fall_visible got=%b exp=0", visible[0]); end
  endtask

  task automatic test_hit_lock;
    int ack_cnt, ret_cnt;
    apply_reset();
    map[4] = 1'b1;
    go_to(66);
    checks++; if (fr(4) !== 5'd16) begin errors++; $display("[TB] FAIL hit_hold got=%0d exp=16", fr(4)); end
    hit[4] = 1'b1;
    go_to(67);
    hit[4] = 1'b0;
    checks++; if (hit_ack[4] !== 1'b1) begin errors++; $display("[TB] FAIL hit_ack_on got=%b exp=1", hit_ack[4]); end
    go_to(68);
    checks++; if (hit_ack[4] !== 1'b0) begin errors++; $display("[TB] FAIL hit_ack_off got=%b exp=0", hit_ack[4]); end
    checks++; if (fr(4) !== 5'd15) begin errors++; $display("[TB] FAIL hit_fall got=%0d exp=15", fr(4)); end
    ack_cnt = 0; ret_cnt = 0;
    for (int c = 69; c <= 140; c++) begin
      go_to(c);
      if (hit_ack[4]) ack_cnt++;
      if (retracted[4]) ret_cnt++;
    end
    checks++; if (ack_cnt != 0) begin errors++; $display("[TB] FAIL hit_ack_extra got=%0d exp=0", ack_cnt); end
    checks++; if (ret_cnt != 1) begin errors++; $display("[TB] FAIL hit_retract_count got=%0d exp=1", ret_cnt); end
    checks++; if (fr(4) !== 5'd0) begin errors++; $display("[TB] FAIL lock_stays_idle got=%0d exp=0", fr(4)); end
    map[4] = 1'b0;
    go_to(141);
    map[4] = 1'b1;
    go_to(143);
    checks++; if (fr(4) !== 5'd0) begin errors++; $display("[TB] FAIL rerise_pre got=%0d exp=0", fr(4)); end
    go_to(144);
    checks++; if (fr(4) !== 5'd1) begin errors++; $display("[TB] FAIL rerise_step1 got=%0d exp=1", fr(4)); end
    go_to(148);
    checks++; if (fr(4) !== 5'd2) begin errors++; $display("[TB] FAIL rerise_step2 got=%0d exp=2", fr(4)); end
  endtask

  task automatic test_early_drop;
    int ret_cnt;
    apply_reset();
    map[2] = 1'b1;
    go_to(28);
    checks++; if (fr(2) !== 5'd7) begin errors++; $display("[TB] FAIL drop_at7 got=%0d exp=7", fr(2)); end
    map[2] = 1'b0;
    ret_cnt = 0;
    for (int c = 29; c <= 56; c++) begin
      go_to(c);
      if (retracted[2]) ret_cnt++;
      if (fr(2) > 5'd7) begin checks++; errors++; $display("[TB] FAIL drop_rose cyc=%0d got=%0d exp<=7", c, fr(2)); end
    end
    checks++; if (fr(2) !== 5'd0)      begin errors++; $display("[TB] FAIL drop_zero got=%0d exp=0", fr(2)); end
    checks++; if (retracted[2] !== 1'b1) begin errors++; $display("[TB] FAIL drop_retract got=%b exp=1", retracted[2]); end
    checks++; if (ret_cnt != 1)        begin errors++; $display("[TB] FAIL drop_retract_count got=%0d exp=1", ret_cnt); end
    map[2] = 1'b1;
    go_to(76);
    checks++; if (fr(2) !== 5'd5) begin errors++; $display("[TB] FAIL second_rise got=%0d exp=5", fr(2)); end
    map[2] = 1'b0;
    go_to(84);
    checks++; if (fr(2) !== 5'd3) begin errors++; $display("[TB] FAIL second_fall got=%0d exp=3", fr(2)); end
    map[2] = 1'b1;
    go_to(88);
    checks++; if (fr(2) !== 5'd4) begin errors++; $display("[TB] FAIL reraise_4 got=%0d exp=4", fr(2)); end
    go_to(92);
    checks++; if (fr(2) !== 5'd5) begin errors++; $display("[TB] FAIL reraise_5 got=%0d exp=5", fr(2)); end
  endtask

  task automatic test_hit_priority;
    apply_reset();
    map[1] = 1'b1;
    go_to(65);
    hit[1] = 1'b1; map[1] = 1'b0; hit[3] = 1'b1;
    go_to(66);
    hit = '0; map[1] = 1'b1;
    checks++; if (hit_ack[1] !== 1'b1) begin errors++; $display("[TB] FAIL prio_ack got=%b exp=1", hit_ack[1]); end
    checks++; if (hit_ack[3] !== 1'b0) begin errors++; $display("[TB] FAIL idle_hit_ack got=%b exp=0", hit_ack[3]); end
    checks++; if ((fr(3) !== 5'd0) || (visible[3] !== 1'b0)) begin errors++; $display("[TB] FAIL idle_hit_state frame=%0d vis=%b exp=0/0", fr(3), visible[3]); end
    go_to(67);
    checks++; if (hit_ack[1] !== 1'b0) begin errors++; $display("[TB] FAIL prio_ack_off got=%b exp=0", hit_ack[1]); end
    go_to(68);
    checks++; if (fr(1) !== 5'd15) begin errors++; $display("[TB] FAIL prio_lock_fall got=%0d exp=15", fr(1)); end
    go_to(72);
    checks++; if (fr(1) !== 5'd14) begin errors++; $display("[TB] FAIL prio_lock_fall2 got=%0d exp=14", fr(1)); end
    checks++; if (fr(3) !== 5'd0) begin errors++; $display("[TB] FAIL idle_hit_later got=%0d exp=0", fr(3)); end
  endtask

  task automatic test_enable_pause;
    apply_reset();
    map[5] = 1'b1;
    go_to(21);
    checks++; if (fr(5) !== 5'd5) begin errors++; $display("[TB] FAIL pause_start got=%0d exp=5", fr(5)); end
    en = 1'b0;
    for (int c = 22; c <= 41; c++) begin
      go_to(c);
      checks++; if (fr(5) !== 5'd5) begin errors++; $display("[TB] FAIL pause_hold cyc=%0d got=%0d exp=5", c, fr(5)); end
    end
    en = 1'b1;
    go_to(43);
    checks++; if (fr(5) !== 5'd5) begin errors++; $display("[TB] FAIL resume_pre got=%0d exp=5", fr(5)); end
    go_to(44);
    checks++; if (fr(5) !== 5'd6) begin errors++; $display("[TB] FAIL resume_step got=%0d exp=6", fr(5)); end
    go_to(47);
    checks++; if (fr(5) !== 5'd6) begin errors++; $display("[TB] FAIL resume_gap got=%0d exp=6", fr(5)); end
    go_to(48);
    checks++; if (fr(5) !== 5'd7) begin errors++; $display("[TB] FAIL resume_step2 got=%0d exp=7", fr(5)); end
  endtask

  task automatic test_async_reset_all;
    apply_reset();
    map = 9'b0_0001_1111;
    go_to(30);
    checks++; if (visible !== 9'b0_0001_1111) begin errors++; $display("[TB] FAIL pre_reset_visible got=%b exp=000011111", visible); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (frames !== '0)  begin errors++; $display("[TB] FAIL async_frames got=%h exp=0", frames); end
    checks++; if ((visible | hit_ack | retracted) !== '0) begin errors++; $display("[TB] FAIL async_outputs vis=%b ack=%b ret=%b exp=0", visible, hit_ack, retracted); end
    apply_reset();
    map = '1;
    go_to(20);
    for (int h = 0; h < NH; h++) begin
      checks++; if (fr(h) !== 5'd5) begin errors++; $display("[TB] FAIL all_rise hole=%0d got=%0d exp=5", h, fr(h)); end
    end
    go_to(64);
    for (int h = 0; h < NH; h++) begin
      checks++; if (fr(h) !== 5'd16) begin errors++; $display("[TB] FAIL all_full hole=%0d got=%0d exp=16", h, fr(h)); end
    end
    checks++; if (visible !== 9'h1FF) begin errors++; $display("[TB] FAIL all_visible got=%b exp=111111111", visible); end
  endtask

  initial begin
    test_reset();
    test_rise_hold_fall();
    test_hit_lock();
    test_early_drop();
    test_hit_priority();
    test_enable_pause();
    test_async_reset_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
